// File: rtl/cla_sub_seq_pkg.sv
// cla_pkg: shared constants, FSM encoding and sizing helper for the
// nibble-serial borrow-lookahead subtractor.
package cla_pkg;
   localparam int NIB = 4;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic int nib_cnt(input int w);
      return w / NIB;
   endfunction
endpackage

// File: rtl/cla_sub_seq_if.sv
// cla_sub_seq_if: operand and result handshakes of the serial subtractor.
interface cla_sub_seq_if #(
   parameter int WIDTH = 16
);
   logic in_valid, in_ready, bin, out_valid, out_ready, bout, zero, busy;
   logic [WIDTH-1:0] a, b, d;
   modport master(output in_valid, a, b, bin, out_ready,
                  input in_ready, out_valid, d, bout, zero, busy);
   modport slave(input in_valid, a, b, bin, out_ready,
                 output in_ready, out_valid, d, bout, zero, busy);
endinterface

// File: rtl/cla_sub_seq_cbl4.sv
// cbl4: combinational 4-bit borrow-lookahead subtract slice, dif = x - y - bi.
module cbl4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       bi,
   output logic [3:0] dif,
   output logic       bo
);
   logic [3:0] g, p;
   logic [3:1] c;
   assign g = ~x & y;
   assign p = ~(x ^ y);
   // every borrow is a flat sum of products over g/p/bi, no chaining
   assign c[1] = g[0] | (p[0] & bi);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
   assign bo   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & bi);
   assign dif = x ^ y ^ {c, bi};
endmodule

// File: rtl/cla_sub_seq.sv
// cla_sub_seq: multi-cycle a - b - bin, one borrow-lookahead nibble per clock
// with the borrow carried between nibbles in a register.
module cla_sub_seq
   import cla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input logic          clk,
   input logic          rst,
   cla_sub_seq_if.slave s
);
   localparam int N  = nib_cnt(WIDTH);
   localparam int IW = N > 1 ? $clog2(N) : 1;
   if (WIDTH % NIB != 0 || WIDTH < NIB) begin : g_bad_width
      $error("cla_sub_seq: WIDTH must be a multiple of 4 and at least 4");
   end
   state_t st;
   logic [WIDTH-1:0] a_l, b_l, d_r, d_nx;
   logic [IW-1:0] idx;
   logic br, bo, bout_r, zero_r;
   logic [NIB-1:0] dif;
   cbl4 u_slice (
      .x  (a_l[idx*NIB +: NIB]),
      .y  (b_l[idx*NIB +: NIB]),
      .bi (br),
      .dif(dif),
      .bo (bo)
   );
   always_comb begin
      d_nx = d_r;
      d_nx[idx*NIB +: NIB] = dif;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st     <= IDLE;
         idx    <= '0;
         br     <= 1'b0;
         d_r    <= '0;
         bout_r <= 1'b0;
         zero_r <= 1'b0;
      end else begin
         case (st)
            IDLE: if (s.in_valid) begin
               a_l <= s.a;
               b_l <= s.b;
               br  <= s.bin;
               idx <= '0;
               st  <= RUN;
            end
            RUN: begin
               d_r <= d_nx;
               br  <= bo;
               idx <= idx + 1'b1;
               // zero is judged on the fully assembled difference
               if (idx == IW'(N - 1)) begin
                  st     <= DONE;
                  bout_r <= bo;
                  zero_r <= d_nx == '0;
               end
            end
            DONE: if (s.out_ready) st <= IDLE;
            default: st <= IDLE;
         endcase
      end
   end
   assign s.in_ready  = st == IDLE;
   assign s.out_valid = st == DONE;
   assign s.busy      = st != IDLE;
   assign s.d         = d_r;
   assign s.bout      = bout_r;
   assign s.zero      = zero_r;
endmodule

// File: tb/tb_cla_sub_seq.sv
// tb_cla_sub_seq: scoreboard bench for the 16-bit and 4-bit serial subtractor
// plus an exhaustive sweep of the standalone slice.
module tb_cla_sub_seq;
   typedef struct {
      logic [16:0] r;
      int          acc;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0, checks = 0, failures = 0;
   exp_t q16[$], q4[$];
   bit seen16 = 0, seen4 = 0;
   logic [3:0] sx, sy, sdif;
   logic sbi, sbo;
   cla_sub_seq_if #(.WIDTH(16)) f ();
   cla_sub_seq_if #(.WIDTH(4)) g ();
   cla_sub_seq #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .s(f));
   cla_sub_seq #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .s(g));
   cbl4 u_s (.x(sx), .y(sy), .bi(sbi), .dif(sdif), .bo(sbo));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask
   task automatic bad(input string nm);
      checks++;
      failures++;
      $display("FAIL %s at cycle %0d", nm, cyc);
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic bi);
      int n = 0;
      logic [16:0] r;
      while (!f.in_ready && n < 100) begin step; n++; end
      if (!f.in_ready) bad("in_ready16_timeout");
      f.a = x; f.b = y; f.bin = bi; f.in_valid = 1'b1;
      r = {1'b0, x} - {1'b0, y} - 17'(bi);
      q16.push_back('{r, cyc + 1});
      step;
      f.in_valid = 1'b0;
   endtask
   task automatic send4(input logic [3:0] x, input logic [3:0] y, input logic bi);
      int n = 0;
      logic [16:0] r;
      while (!g.in_ready && n < 100) begin step; n++; end
      if (!g.in_ready) bad("in_ready4_timeout");
      g.a = x; g.b = y; g.bin = bi; g.in_valid = 1'b1;
      r = {13'd0, ({1'b0, x} - {1'b0, y} - 5'(bi))};
      q4.push_back('{r, cyc + 1});
      step;
      g.in_valid = 1'b0;
   endtask
   task automatic drain;
      int n = 0;
      while ((q16.size() != 0 || q4.size() != 0) && n < 200) begin step; n++; end
      if (q16.size() != 0 || q4.size() != 0) bad("drain_timeout");
      q16.delete();
      q4.delete();
   endtask
   // monitors: compare every cycle a result is presented, pop on handshake
   always @(negedge clk) if (f.out_valid) begin
      if (q16.size() == 0) bad("unexpected16");
      else begin
         if (!seen16) chk("lat16", cyc - q16[0].acc, 4);
         seen16 = 1;
         chk("d16", 32'(f.d), 32'(q16[0].r[15:0]));
         chk("bout16", 32'(f.bout), 32'(q16[0].r[16]));
         chk("zero16", 32'(f.zero), 32'(q16[0].r[15:0] == 16'd0));
         chk("in_ready_done16", 32'(f.in_ready), 0);
         if (f.out_ready) begin void'(q16.pop_front()); seen16 = 0; end
      end
   end
   always @(negedge clk) if (g.out_valid) begin
      if (q4.size() == 0) bad("unexpected4");
      else begin
         if (!seen4) chk("lat4", cyc - q4[0].acc, 1);
         seen4 = 1;
         chk("d4", 32'(g.d), 32'(q4[0].r[3:0]));
         chk("bout4", 32'(g.bout), 32'(q4[0].r[4]));
         chk("zero4", 32'(g.zero), 32'(q4[0].r[3:0] == 4'd0));
         if (g.out_ready) begin void'(q4.pop_front()); seen4 = 0; end
      end
   end
   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      logic [4:0] e;
      f.in_valid = 0; f.a = '0; f.b = '0; f.bin = 0; f.out_ready = 1;
      g.in_valid = 0; g.a = '0; g.b = '0; g.bin = 0; g.out_ready = 1;
      for (int i = 0; i < 512; i++) begin
         {sx, sy, sbi} = 9'(i);
         #1;
         e = {1'b0, sx} - {1'b0, sy} - 5'(sbi);
         chk("cbl4", 32'({sbo, sdif}), 32'(e));
      end
      step; step;
      chk("rst_in_ready", 32'(f.in_ready), 1);
      chk("rst_out_valid", 32'(f.out_valid), 0);
      chk("rst_busy", 32'(f.busy), 0);
      chk("rst_d", 32'(f.d), 0);
      chk("rst_bout_zero", 32'({f.bout, f.zero}), 0);
      rst = 0;
      send16(16'h1234, 16'h0234, 0);
      send16(16'h0000, 16'h0001, 0);
      send16(16'h8000, 16'h8000, 1);
      send16(16'h8000, 16'h8000, 0);
      send16(16'hFFFF, 16'hFFFF, 1);
      drain;
      // backpressure: result must hold while out_ready is low
      f.out_ready = 0;
      send16(16'hBEEF, 16'hCAFE, 1);
      n = 0;
      while (!f.out_valid && n < 20) begin step; n++; end
      if (!f.out_valid) bad("out_valid_timeout");
      repeat (5) step;
      f.out_ready = 1;
      step;
      chk("bp_in_ready", 32'(f.in_ready), 1);
      chk("bp_out_valid", 32'(f.out_valid), 0);
      drain;
      // operand changes while running must be ignored
      send16(16'hAAAA, 16'h5555, 0);
      f.a = 16'hFFFF; f.b = 16'h0000; f.bin = 1; f.in_valid = 1;
      step; step;
      f.in_valid = 0;
      drain;
      // reset mid-operation discards the result
      send16(16'h1111, 16'h0001, 0);
      step;
      chk("run_busy", 32'(f.busy), 1);
      rst = 1;
      step;
      rst = 0;
      q16.delete();
      chk("mid_rst_busy", 32'(f.busy), 0);
      chk("mid_rst_out_valid", 32'(f.out_valid), 0);
      chk("mid_rst_d", 32'(f.d), 0);
      chk("mid_rst_in_ready", 32'(f.in_ready), 1);
      send16(16'h00FF, 16'h0100, 0);
      drain;
      repeat (40) send16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      drain;
      for (int i = 0; i < 512; i++) send4(4'(i >> 5), 4'(i >> 1), 1'(i));
      drain;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
